// File: rtl/cpu_stat_counter.sv
// Execution-statistics counters for the single-cycle CPU, plus a sequential
// double-dabble converter that turns one selected count into 8 packed BCD digits.
module cpu_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             halt,
  input  logic             is_jump,
  input  logic             is_branch_taken,
  input  logic             clr,
  input  logic             bcd_start,
  input  logic [1:0]       bcd_sel,
  output logic [CNT_W-1:0] total_cycles,
  output logic [CNT_W-1:0] uncondi_branch_num,
  output logic [CNT_W-1:0] condi_branch_num,
  output logic             bcd_busy,
  output logic             bcd_done,
  output logic [31:0]      bcd_out,
  output logic             bcd_overflow
);

  localparam int BCD_W = 32;
  localparam int SC_W  = $clog2(CNT_W);
  localparam logic [SC_W-1:0]  SHIFT_LAST = SC_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] BCD_LIMIT  = CNT_W'(100_000_000);

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state;
  logic [SC_W-1:0]   shift_cnt;
  logic              ovf_pend;
  logic [CNT_W-1:0]  shift_reg;
  logic [BCD_W-1:0]  digits;
  logic [BCD_W-1:0]  digits_adj;
  logic [BCD_W-1:0]  digits_next;
  logic [CNT_W-1:0]  snap;
  logic              cnt_en;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    logic [3:0]       n;
    r = '0;
    for (int i = 0; i < BCD_W / 4; i++) begin
      n = d[4*i +: 4];
      r[4*i +: 4] = (n >= 4'd5) ? n + 4'd3 : n;
    end
    return r;
  endfunction

  assign cnt_en      = run_en & ~halt;
  assign digits_adj  = add3_digits(digits);
  // The bit leaving digit 7 is dropped, so the result is the value modulo 10^8.
  assign digits_next = {digits_adj[BCD_W-2:0], shift_reg[CNT_W-1]};

  always_comb begin
    snap = '0;
    case (bcd_sel)
      2'b00:   snap = total_cycles;
      2'b01:   snap = uncondi_branch_num;
      2'b10:   snap = condi_branch_num;
      default: snap = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cycles       <= '0;
      uncondi_branch_num <= '0;
      condi_branch_num   <= '0;
    end else if (clr) begin
      total_cycles       <= '0;
      uncondi_branch_num <= '0;
      condi_branch_num   <= '0;
    end else if (cnt_en) begin
      total_cycles <= total_cycles + CNT_W'(1);
      if (is_jump)
        uncondi_branch_num <= uncondi_branch_num + CNT_W'(1);
      if (is_branch_taken)
        condi_branch_num <= condi_branch_num + CNT_W'(1);
    end
  end

  // Conversion datapath: loaded from the snapshot, then shifted once per CONV cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && bcd_start) begin
      shift_reg <= snap;
      digits    <= '0;
    end else if (state == CONV) begin
      shift_reg <= {shift_reg[CNT_W-2:0], 1'b0};
      digits    <= digits_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift_cnt    <= '0;
      ovf_pend     <= 1'b0;
      bcd_busy     <= 1'b0;
      bcd_done     <= 1'b0;
      bcd_out      <= '0;
      bcd_overflow <= 1'b0;
    end else begin
      bcd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bcd_start) begin
            ovf_pend  <= (snap >= BCD_LIMIT);
            shift_cnt <= '0;
            bcd_busy  <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          shift_cnt <= shift_cnt + SC_W'(1);
          if (shift_cnt == SHIFT_LAST) begin
            bcd_out      <= digits_next;
            bcd_overflow <= ovf_pend;
            bcd_done     <= 1'b1;
            bcd_busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_stat_counter.sv
// Directed bench for cpu_stat_counter: counting, halt/clear/wrap, BCD conversion
// timing and values, ignored restarts, and reset in the middle of a conversion.
module tb_cpu_stat_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        halt;
  logic        is_jump;
  logic        is_branch_taken;
  logic        clr;
  logic        bcd_start;
  logic [1:0]  bcd_sel;
  logic [31:0] total_cycles;
  logic [31:0] uncondi_branch_num;
  logic [31:0] condi_branch_num;
  logic        bcd_busy;
  logic        bcd_done;
  logic [31:0] bcd_out;
  logic        bcd_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_stat_counter #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .halt(halt), .is_jump(is_jump),
    .is_branch_taken(is_branch_taken), .clr(clr), .bcd_start(bcd_start),
    .bcd_sel(bcd_sel), .total_cycles(total_cycles),
    .uncondi_branch_num(uncondi_branch_num), .condi_branch_num(condi_branch_num),
    .bcd_busy(bcd_busy), .bcd_done(bcd_done), .bcd_out(bcd_out),
    .bcd_overflow(bcd_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Preload a counter so that large conversions need no millions of cycles.
  task automatic preload(input logic [1:0] sel, input logic [31:0] v);
    case (sel)
      2'b00:   dut.total_cycles = v;
      2'b01:   dut.uncondi_branch_num = v;
      default: dut.condi_branch_num = v;
    endcase
    #1;
  endtask

  task automatic run_conv(input logic [1:0] sel, input logic [31:0] exp_bcd,
                          input logic exp_ovf, input bit disturb, input string name);
    int done_cnt = 0;
    int done_at  = -1;
    int busy_cyc = 0;
    bcd_sel   = sel;
    bcd_start = 1'b1;
    step();
    bcd_start = 1'b0;
    n_assert++;
    if (bcd_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b want 1", name, bcd_busy);
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bcd_done === 1'b1) begin done_cnt++; done_at = k; end
      if (bcd_busy === 1'b1) busy_cyc++;
      if (disturb) begin
        if (k == 4) begin bcd_start = 1'b1; bcd_sel = 2'b11; run_en = 1'b1; end
        if (k == 5) bcd_start = 1'b0;
        if (k == 8) clr = 1'b1;
        if (k == 9) begin clr = 1'b0; run_en = 1'b0; end
      end
    end
    n_assert++;
    if (done_cnt != 1 || done_at != 32) begin
      n_fail++;
      $display("FAIL %s done_pulse: got count %0d at E%0d want count 1 at E32", name, done_cnt, done_at);
    end
    n_assert++;
    if (busy_cyc != 31) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d want 31 cycles after E0", name, busy_cyc);
    end
    n_assert++;
    if (bcd_out !== exp_bcd) begin
      n_fail++;
      $display("FAIL %s bcd_out: got %h want %h", name, bcd_out, exp_bcd);
    end
    n_assert++;
    if (bcd_overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s bcd_overflow: got %b want %b", name, bcd_overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run_en = 1'b0; halt = 1'b0; is_jump = 1'b0; is_branch_taken = 1'b0;
    clr = 1'b0; bcd_start = 1'b0; bcd_sel = 2'b00;
    step(); step();
    rst = 1'b0;
    step();
    n_assert++;
    if ({total_cycles, uncondi_branch_num, condi_branch_num} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h %h %h want 0", total_cycles, uncondi_branch_num, condi_branch_num);
    end
    n_assert++;
    if ({bcd_busy, bcd_done, bcd_overflow, bcd_out} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_bcd: got busy %b done %b ovf %b out %h want all 0", bcd_busy, bcd_done, bcd_overflow, bcd_out);
    end
  endtask

  task automatic test_counting();
    run_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      is_jump         = (i == 0 || i == 3 || i == 7);
      is_branch_taken = (i == 2 || i == 7);
      step();
    end
    is_jump = 1'b0; is_branch_taken = 1'b0;
    halt = 1'b1;
    n_assert++;
    if (total_cycles !== 32'd10 || uncondi_branch_num !== 32'd3 || condi_branch_num !== 32'd2) begin
      n_fail++;
      $display("FAIL count_run: got %0d %0d %0d want 10 3 2", total_cycles, uncondi_branch_num, condi_branch_num);
    end
    for (int i = 0; i < 5; i++) begin
      is_jump = 1'b1; is_branch_taken = 1'b1;
      step();
    end
    is_jump = 1'b0; is_branch_taken = 1'b0; halt = 1'b0; run_en = 1'b0;
    n_assert++;
    if (total_cycles !== 32'd10 || uncondi_branch_num !== 32'd3 || condi_branch_num !== 32'd2) begin
      n_fail++;
      $display("FAIL count_halt: got %0d %0d %0d want 10 3 2", total_cycles, uncondi_branch_num, condi_branch_num);
    end
  endtask

  task automatic test_convert();
    preload(2'b00, 32'd12_345_678);
    run_conv(2'b00, 32'h1234_5678, 1'b0, 0, "conv_total");
    preload(2'b01, 32'd123_456_789);
    run_conv(2'b01, 32'h2345_6789, 1'b1, 0, "conv_uncond_ovf");
    preload(2'b10, 32'hFFFF_FFFF);
    run_conv(2'b10, 32'h9496_7295, 1'b1, 0, "conv_cond_max");
    run_conv(2'b11, 32'h0000_0000, 1'b0, 0, "conv_reserved");
  endtask

  task automatic test_back_to_back();
    preload(2'b00, 32'd12_345_678);
    run_conv(2'b00, 32'h1234_5678, 1'b0, 1, "conv_disturbed");
    n_assert++;
    if (total_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_during_conv: got %0d want 0", total_cycles);
    end
  endtask

  task automatic test_clr_wrap();
    preload(2'b00, 32'd5);
    run_en = 1'b1; clr = 1'b1; is_jump = 1'b1; is_branch_taken = 1'b1;
    step();
    clr = 1'b0; run_en = 1'b0; is_jump = 1'b0; is_branch_taken = 1'b0;
    n_assert++;
    if ({total_cycles, uncondi_branch_num, condi_branch_num} !== 96'd0) begin
      n_fail++;
      $display("FAIL clr_priority: got %h %h %h want 0", total_cycles, uncondi_branch_num, condi_branch_num);
    end
    preload(2'b00, 32'hFFFF_FFFF);
    preload(2'b10, 32'hFFFF_FFFF);
    run_en = 1'b1; is_branch_taken = 1'b1;
    step();
    run_en = 1'b0; is_branch_taken = 1'b0;
    n_assert++;
    if (total_cycles !== 32'd0 || condi_branch_num !== 32'd0 || uncondi_branch_num !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap: got %h %h %h want 0 0 0", total_cycles, uncondi_branch_num, condi_branch_num);
    end
  endtask

  task automatic test_rst_mid();
    int done_cnt = 0;
    preload(2'b00, 32'd99_999_999);
    bcd_sel = 2'b00; bcd_start = 1'b1;
    step();
    bcd_start = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if (bcd_busy !== 1'b0 || bcd_done !== 1'b0 || bcd_out !== 32'd0 || bcd_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy %b done %b out %h ovf %b want 0 0 0 0", bcd_busy, bcd_done, bcd_out, bcd_overflow);
    end
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bcd_done === 1'b1 || bcd_busy === 1'b1) done_cnt++;
    end
    n_assert++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d active cycles want 0", done_cnt);
    end
    preload(2'b00, 32'd87_654_321);
    run_conv(2'b00, 32'h8765_4321, 1'b0, 0, "conv_after_rst");
  endtask

  initial begin
    test_reset();
    test_counting();
    test_convert();
    test_back_to_back();
    test_clr_wrap();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
